// File: rtl/jtexterm_ba_resp.sv
// -----------------------------------------------------------------------------
// jtexterm_ba_resp
//
// Four-bank read arbiter and responder for an external word-wide memory, with
// a download/read-back port that takes priority over the banks.
//
// A bank requester holds ba_rd[i] until it sees ba_ack[i]. It then receives one
// or two data words on the shared data_read bus. BURST32[i] selects one or two
// words for bank i. The download port (prog_we / prog_rd) always moves a single
// word. The memory side gets one mem_rd or mem_we pulse per word, and each word
// completes with a one-cycle mem_ok.
//
// Ports
//   clk, rst_n                 system clock; synchronous active-low reset
//   ba0_addr..ba3_addr [AW]    word address presented by each bank requester
//   ba_rd        [4]           read request per bank, held until ba_ack
//   ba_ack       [4]           one-cycle acceptance pulse
//   ba_dst       [4]           first data word valid on data_read
//   ba_dok       [4]           any data word valid on data_read
//   ba_rdy       [4]           last data word valid, transaction complete
//   data_read    [16]          read data shared by banks and read-back
//   prog_we, prog_rd           download write / read-back request, held to ack
//   prog_addr [AW], prog_ba [2], prog_data [16], prog_mask [2] (active low)
//   prog_ack, prog_rdy         one-cycle acceptance / completion pulses
//   mem_addr [AW+2]            {bank, word address}
//   mem_rd, mem_we             one-cycle command pulses
//   mem_din [16], mem_mask [2] write data and active-low byte enables
//   mem_dout [16], mem_ok      read data and one-cycle completion from memory
// -----------------------------------------------------------------------------
module jtexterm_ba_resp #(
    parameter logic [3:0] BURST32 = 4'b1000,
    parameter int         AW      = 22
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic [AW-1:0] ba0_addr,
    input  logic [AW-1:0] ba1_addr,
    input  logic [AW-1:0] ba2_addr,
    input  logic [AW-1:0] ba3_addr,
    input  logic [3:0]    ba_rd,
    output logic [3:0]    ba_ack,
    output logic [3:0]    ba_dst,
    output logic [3:0]    ba_dok,
    output logic [3:0]    ba_rdy,
    output logic [15:0]   data_read,

    input  logic          prog_we,
    input  logic          prog_rd,
    input  logic [AW-1:0] prog_addr,
    input  logic [1:0]    prog_ba,
    input  logic [15:0]   prog_data,
    input  logic [1:0]    prog_mask,
    output logic          prog_ack,
    output logic          prog_rdy,

    output logic [AW+1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_we,
    output logic [15:0]   mem_din,
    output logic [1:0]    mem_mask,
    input  logic [15:0]   mem_dout,
    input  logic          mem_ok
);

    typedef enum logic [1:0] {IDLE, ACK, ISSUE, WAIT} state_t;

    // Transaction context, captured at grant time
    state_t        state,     nxt_state;
    logic [1:0]    gnt_bank,  nxt_gnt_bank;
    logic [1:0]    last_bank, nxt_last_bank;
    logic [AW-1:0] txn_addr,  nxt_txn_addr;
    logic          txn_burst, nxt_txn_burst;
    logic          txn_prog,  nxt_txn_prog;
    logic          txn_we,    nxt_txn_we;
    logic          word,      nxt_word;

    // Next values of the registered outputs
    logic [3:0]    nxt_ba_ack, nxt_ba_dst, nxt_ba_dok, nxt_ba_rdy;
    logic [15:0]   nxt_data_read;
    logic          nxt_prog_ack, nxt_prog_rdy;
    logic [AW+1:0] nxt_mem_addr;
    logic          nxt_mem_rd, nxt_mem_we;
    logic [15:0]   nxt_mem_din;
    logic [1:0]    nxt_mem_mask;

    // Round-robin arbitration result
    logic          rr_valid;
    logic [1:0]    rr_bank;
    logic [AW-1:0] rr_addr;

    logic [3:0]    gnt_onehot;
    logic [AW-1:0] txn_addr_p1;

    assign gnt_onehot  = 4'b0001 << gnt_bank;
    // The second word of a burst wraps inside the bank. The bank field is untouched.
    assign txn_addr_p1 = txn_addr + {{(AW-1){1'b0}}, 1'b1};

    // Search order is last_bank+1, +2, +3, +4 (mod 4). The loop runs from the
    // farthest candidate to the nearest, so the nearest requester is assigned
    // last and wins.
    always_comb begin
        rr_valid = 1'b0;
        rr_bank  = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            if (ba_rd[last_bank + 2'(i)]) begin
                rr_valid = 1'b1;
                rr_bank  = last_bank + 2'(i);
            end
        end
    end

    always_comb begin
        case (rr_bank)
            2'd0:    rr_addr = ba0_addr;
            2'd1:    rr_addr = ba1_addr;
            2'd2:    rr_addr = ba2_addr;
            default: rr_addr = ba3_addr;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default before the case, so no path can leave
        // one unassigned and infer a latch. Pulses default low; held values
        // default to themselves.
        nxt_state     = state;
        nxt_gnt_bank  = gnt_bank;
        nxt_last_bank = last_bank;
        nxt_txn_addr  = txn_addr;
        nxt_txn_burst = txn_burst;
        nxt_txn_prog  = txn_prog;
        nxt_txn_we    = txn_we;
        nxt_word      = word;
        nxt_ba_ack    = 4'b0000;
        nxt_ba_dst    = 4'b0000;
        nxt_ba_dok    = 4'b0000;
        nxt_ba_rdy    = 4'b0000;
        nxt_data_read = data_read;
        nxt_prog_ack  = 1'b0;
        nxt_prog_rdy  = 1'b0;
        nxt_mem_addr  = mem_addr;
        nxt_mem_rd    = 1'b0;
        nxt_mem_we    = 1'b0;
        nxt_mem_din   = mem_din;
        nxt_mem_mask  = mem_mask;

        case (state)
            IDLE: begin
                nxt_word = 1'b0;
                if (prog_we || prog_rd) begin
                    // The download port outranks every bank and does not move the
                    // round-robin pointer.
                    nxt_state     = ACK;
                    nxt_gnt_bank  = prog_ba;
                    nxt_txn_addr  = prog_addr;
                    nxt_txn_burst = 1'b0;
                    nxt_txn_prog  = 1'b1;
                    nxt_txn_we    = prog_we;
                    nxt_mem_din   = prog_data;
                    nxt_mem_mask  = prog_mask;
                    nxt_prog_ack  = 1'b1;
                end else if (rr_valid) begin
                    nxt_state     = ACK;
                    nxt_gnt_bank  = rr_bank;
                    nxt_last_bank = rr_bank;
                    nxt_txn_addr  = rr_addr;
                    nxt_txn_burst = BURST32[rr_bank];
                    nxt_txn_prog  = 1'b0;
                    nxt_txn_we    = 1'b0;
                    nxt_ba_ack    = 4'b0001 << rr_bank;
                end
            end

            ACK: begin
                nxt_state    = ISSUE;
                nxt_mem_addr = {gnt_bank, txn_addr};
                nxt_mem_rd   = ~txn_we;
                nxt_mem_we   = txn_we;
            end

            ISSUE: nxt_state = WAIT;

            WAIT: begin
                if (mem_ok) begin
                    if (txn_prog) begin
                        nxt_prog_rdy = 1'b1;
                        if (!txn_we) nxt_data_read = mem_dout;
                        nxt_state = IDLE;
                    end else begin
                        nxt_data_read = mem_dout;
                        nxt_ba_dok    = gnt_onehot;
                        if (!word) nxt_ba_dst = gnt_onehot;
                        if (txn_burst && !word) begin
                            // Issue the second word straight from WAIT.
                            nxt_word     = 1'b1;
                            nxt_state    = ISSUE;
                            nxt_mem_addr = {gnt_bank, txn_addr_p1};
                            nxt_mem_rd   = 1'b1;
                        end else begin
                            nxt_ba_rdy = gnt_onehot;
                            nxt_word   = 1'b0;
                            nxt_state  = IDLE;
                        end
                    end
                end
            end

            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments, so every register samples
        // the pre-edge values no matter how the statements are ordered.
        if (!rst_n) begin
            state     <= IDLE;
            gnt_bank  <= 2'd0;
            last_bank <= 2'd3;
            txn_addr  <= '0;
            txn_burst <= 1'b0;
            txn_prog  <= 1'b0;
            txn_we    <= 1'b0;
            word      <= 1'b0;
            ba_ack    <= 4'b0000;
            ba_dst    <= 4'b0000;
            ba_dok    <= 4'b0000;
            ba_rdy    <= 4'b0000;
            data_read <= 16'h0000;
            prog_ack  <= 1'b0;
            prog_rdy  <= 1'b0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_we    <= 1'b0;
            mem_din   <= 16'h0000;
            mem_mask  <= 2'b00;
        end else begin
            state     <= nxt_state;
            gnt_bank  <= nxt_gnt_bank;
            last_bank <= nxt_last_bank;
            txn_addr  <= nxt_txn_addr;
            txn_burst <= nxt_txn_burst;
            txn_prog  <= nxt_txn_prog;
            txn_we    <= nxt_txn_we;
            word      <= nxt_word;
            ba_ack    <= nxt_ba_ack;
            ba_dst    <= nxt_ba_dst;
            ba_dok    <= nxt_ba_dok;
            ba_rdy    <= nxt_ba_rdy;
            data_read <= nxt_data_read;
            prog_ack  <= nxt_prog_ack;
            prog_rdy  <= nxt_prog_rdy;
            mem_addr  <= nxt_mem_addr;
            mem_rd    <= nxt_mem_rd;
            mem_we    <= nxt_mem_we;
            mem_din   <= nxt_mem_din;
            mem_mask  <= nxt_mem_mask;
        end
    end

endmodule

// File: tb/tb_jtexterm_ba_resp.sv
// -----------------------------------------------------------------------------
// tb_jtexterm_ba_resp
//
// Bench for jtexterm_ba_resp. Each test queues the grants, memory commands and
// data returns it expects, then drives requests. tick() advances one clock. On
// the falling edge it acts as the memory and the requesters, and it compares
// every DUT strobe event with the head of the matching queue.
// -----------------------------------------------------------------------------
module tb_jtexterm_ba_resp;

    localparam int AW = 22;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] ba0_addr, ba1_addr, ba2_addr, ba3_addr;
    logic [3:0]    ba_rd;
    logic [3:0]    ba_ack, ba_dst, ba_dok, ba_rdy;
    logic [15:0]   data_read;
    logic          prog_we, prog_rd;
    logic [AW-1:0] prog_addr;
    logic [1:0]    prog_ba;
    logic [15:0]   prog_data;
    logic [1:0]    prog_mask;
    logic          prog_ack, prog_rdy;
    logic [AW+1:0] mem_addr;
    logic          mem_rd, mem_we;
    logic [15:0]   mem_din;
    logic [1:0]    mem_mask;
    logic [15:0]   mem_dout;
    logic          mem_ok;

    always #5 clk = ~clk;

    jtexterm_ba_resp #(.BURST32(4'b1000), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ba0_addr(ba0_addr), .ba1_addr(ba1_addr), .ba2_addr(ba2_addr), .ba3_addr(ba3_addr),
        .ba_rd(ba_rd), .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_dok(ba_dok), .ba_rdy(ba_rdy),
        .data_read(data_read),
        .prog_we(prog_we), .prog_rd(prog_rd), .prog_addr(prog_addr), .prog_ba(prog_ba),
        .prog_data(prog_data), .prog_mask(prog_mask), .prog_ack(prog_ack), .prog_rdy(prog_rdy),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_we(mem_we), .mem_din(mem_din),
        .mem_mask(mem_mask), .mem_dout(mem_dout), .mem_ok(mem_ok)
    );

    typedef struct { bit prog; logic [1:0] bank; } ack_t;
    typedef struct { bit we; logic [AW+1:0] addr; logic [15:0] din; logic [1:0] mask; } cmd_t;
    typedef struct { bit prog; bit rd; logic [1:0] bank; logic [15:0] data; bit dst; bit rdy; } rsp_t;

    ack_t exp_ack[$];
    cmd_t exp_cmd[$];
    rsp_t exp_rsp[$];
    int   ack_cyc[$];
    int   rsp_cyc[$];

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    logic [3:0]  burst_cfg = 4'b1000;
    int          mem_delay = 1;
    int          pend_cnt  = 0;
    logic [15:0] pend_data = 16'h0000;
    logic [15:0] mem [int];

    // Memory contents: explicitly written words, or a fixed pattern of the address.
    function automatic logic [15:0] mem_word(input logic [AW+1:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return a[15:0] ^ {a[23:16], 8'hC3};
    endfunction

    task automatic expect_read(input logic [1:0] bank, input logic [AW-1:0] a);
        logic [AW-1:0] a1;
        logic [AW+1:0] full0, full1;
        a1    = a + 22'd1;
        full0 = {bank, a};
        full1 = {bank, a1};
        exp_ack.push_back('{prog: 1'b0, bank: bank});
        exp_cmd.push_back('{we: 1'b0, addr: full0, din: 16'h0, mask: 2'b00});
        if (burst_cfg[bank]) begin
            exp_cmd.push_back('{we: 1'b0, addr: full1, din: 16'h0, mask: 2'b00});
            exp_rsp.push_back('{prog: 1'b0, rd: 1'b1, bank: bank, data: mem_word(full0), dst: 1'b1, rdy: 1'b0});
            exp_rsp.push_back('{prog: 1'b0, rd: 1'b1, bank: bank, data: mem_word(full1), dst: 1'b0, rdy: 1'b1});
        end else begin
            exp_rsp.push_back('{prog: 1'b0, rd: 1'b1, bank: bank, data: mem_word(full0), dst: 1'b1, rdy: 1'b1});
        end
    endtask

    task automatic expect_prog(input bit we, input logic [1:0] bank, input logic [AW-1:0] a,
                               input logic [15:0] din, input logic [1:0] mask);
        logic [AW+1:0] full;
        full = {bank, a};
        exp_ack.push_back('{prog: 1'b1, bank: 2'd0});
        exp_cmd.push_back('{we: we, addr: full, din: din, mask: mask});
        exp_rsp.push_back('{prog: 1'b1, rd: !we, bank: 2'd0, data: mem_word(full), dst: 1'b0, rdy: 1'b0});
    endtask

    // One clock: memory model, requester release and scoreboard compare, all at negedge.
    task automatic tick();
        ack_t        ea;
        cmd_t        ec;
        rsp_t        er;
        logic [3:0]  oh;
        logic [15:0] old;
        @(negedge clk);
        cycle++;

        if (ba_ack != 4'b0000 || prog_ack) begin
            checks++;
            ack_cyc.push_back(cycle);
            if (exp_ack.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ack: ba_ack=%b prog_ack=%b, wanted no grant", ba_ack, prog_ack);
            end else begin
                ea = exp_ack.pop_front();
                oh = ea.prog ? 4'b0000 : (4'b0001 << ea.bank);
                if (ba_ack !== oh || prog_ack !== ea.prog) begin
                    failures++;
                    $display("FAIL grant_order: ba_ack=%b prog_ack=%b, wanted ba_ack=%b prog_ack=%b",
                             ba_ack, prog_ack, oh, ea.prog);
                end
            end
            ba_rd = ba_rd & ~ba_ack;
            if (prog_ack) begin
                prog_we = 1'b0;
                prog_rd = 1'b0;
            end
        end

        mem_ok   = 1'b0;
        mem_dout = 16'h5EED;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                mem_ok   = 1'b1;
                mem_dout = pend_data;
            end
        end

        if (mem_rd || mem_we) begin
            checks++;
            if (exp_cmd.size() == 0) begin
                failures++;
                $display("FAIL unexpected_mem_cmd: rd=%b we=%b addr=%h, wanted none", mem_rd, mem_we, mem_addr);
            end else begin
                ec = exp_cmd.pop_front();
                if (mem_we !== ec.we || mem_rd !== !ec.we || mem_addr !== ec.addr ||
                    (ec.we && (mem_din !== ec.din || mem_mask !== ec.mask))) begin
                    failures++;
                    $display("FAIL mem_cmd: rd=%b we=%b addr=%h din=%h mask=%b, wanted we=%b addr=%h din=%h mask=%b",
                             mem_rd, mem_we, mem_addr, mem_din, mem_mask, ec.we, ec.addr, ec.din, ec.mask);
                end
            end
            if (mem_we) begin
                old = mem_word(mem_addr);
                mem[int'(mem_addr)] = {mem_mask[1] ? old[15:8] : mem_din[15:8],
                                       mem_mask[0] ? old[7:0]  : mem_din[7:0]};
            end
            pend_data = mem_word(mem_addr);
            pend_cnt  = mem_delay;
        end

        if (ba_dok != 4'b0000 || ba_dst != 4'b0000 || ba_rdy != 4'b0000 || prog_rdy) begin
            checks++;
            rsp_cyc.push_back(cycle);
            if (exp_rsp.size() == 0) begin
                failures++;
                $display("FAIL unexpected_response: dst=%b dok=%b rdy=%b prog_rdy=%b data=%h, wanted none",
                         ba_dst, ba_dok, ba_rdy, prog_rdy, data_read);
            end else begin
                er = exp_rsp.pop_front();
                oh = er.prog ? 4'b0000 : (4'b0001 << er.bank);
                if (prog_rdy !== er.prog || ba_dok !== oh ||
                    ba_dst !== (er.dst ? oh : 4'b0000) || ba_rdy !== (er.rdy ? oh : 4'b0000) ||
                    (er.rd && data_read !== er.data)) begin
                    failures++;
                    $display("FAIL response: dst=%b dok=%b rdy=%b prog_rdy=%b data=%h, wanted dst=%b dok=%b rdy=%b prog_rdy=%b data=%h",
                             ba_dst, ba_dok, ba_rdy, prog_rdy, data_read,
                             er.dst ? oh : 4'b0000, oh, er.rdy ? oh : 4'b0000, er.prog, er.data);
                end
            end
        end
    endtask

    task automatic wait_idle(input int budget, input string what);
        int n = 0;
        while ((exp_ack.size() != 0 || exp_cmd.size() != 0 || exp_rsp.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_ack.size() != 0 || exp_cmd.size() != 0 || exp_rsp.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: pending ack=%0d cmd=%0d rsp=%0d after %0d cycles, wanted all 0",
                     what, exp_ack.size(), exp_cmd.size(), exp_rsp.size(), budget);
            exp_ack.delete();
            exp_cmd.delete();
            exp_rsp.delete();
        end
        repeat (2) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++;
        if ({ba_ack, ba_dst, ba_dok, ba_rdy} !== 16'h0 || prog_ack !== 1'b0 || prog_rdy !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes: ack=%b dst=%b dok=%b rdy=%b pack=%b prdy=%b, wanted all 0",
                     ba_ack, ba_dst, ba_dok, ba_rdy, prog_ack, prog_rdy);
        end
        checks++;
        if (mem_rd !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 24'h0 || data_read !== 16'h0) begin
            failures++;
            $display("FAIL reset_mem: rd=%b we=%b addr=%h data=%h, wanted 0 0 000000 0000",
                     mem_rd, mem_we, mem_addr, data_read);
        end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_single();
        mem_delay = 2;
        ba0_addr  = 22'h1234;
        mem[24'h001234] = 16'hBEEF;
        expect_read(2'd0, ba0_addr);
        ba_rd = 4'b0001;
        wait_idle(30, "single");
        repeat (3) tick();
        checks++;
        if (data_read !== 16'hBEEF) begin
            failures++;
            $display("FAIL data_hold: data_read=%h, wanted BEEF", data_read);
        end
    endtask

    task automatic test_burst_wrap();
        mem_delay = 1;
        ba3_addr  = 22'h3FFFFF;
        mem[24'hFFFFFF] = 16'h1111;
        mem[24'hC00000] = 16'h2222;
        expect_read(2'd3, ba3_addr);
        ba_rd = 4'b1000;
        wait_idle(30, "burst_wrap");
    endtask

    task automatic test_round_robin();
        mem_delay = 1;
        ba0_addr = 22'h000100;
        ba1_addr = 22'h000200;
        ba2_addr = 22'h000300;
        ba3_addr = 22'h000400;
        for (int b = 0; b < 4; b++) expect_read(2'(b), 22'(32'h100 * (b + 1)));
        ba_rd = 4'b1111;
        wait_idle(80, "round_robin_all");
        expect_read(2'd0, ba0_addr);
        expect_read(2'd2, ba2_addr);
        ba_rd = 4'b0101;
        wait_idle(40, "round_robin_pair");
    endtask

    task automatic test_back_to_back();
        mem_delay = 1;
        ack_cyc.delete();
        rsp_cyc.delete();
        ba0_addr = 22'h0ABCDE;
        ba1_addr = 22'h012345;
        expect_read(2'd0, ba0_addr);
        expect_read(2'd1, ba1_addr);
        ba_rd = 4'b0011;
        wait_idle(40, "back_to_back");
        checks++;
        if (ack_cyc.size() != 2 || rsp_cyc.size() != 2) begin
            failures++;
            $display("FAIL b2b_events: acks=%0d responses=%0d, wanted 2 and 2", ack_cyc.size(), rsp_cyc.size());
        end else begin
            if (rsp_cyc[0] - ack_cyc[0] != 3) begin
                failures++;
                $display("FAIL min_latency: ack->rdy=%0d cycles, wanted 3", rsp_cyc[0] - ack_cyc[0]);
            end
            checks++;
            if (ack_cyc[1] - ack_cyc[0] != 4) begin
                failures++;
                $display("FAIL rearbitration: ack spacing=%0d cycles, wanted 4", ack_cyc[1] - ack_cyc[0]);
            end
        end
    endtask

    task automatic test_withdrawn();
        int n = 0;
        mem_delay = 4;
        ba0_addr  = 22'h000777;
        expect_read(2'd0, ba0_addr);
        ba_rd = 4'b0001;
        while (exp_cmd.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        ba_rd[2] = 1'b1;
        tick();
        ba_rd[2] = 1'b0;
        wait_idle(30, "withdrawn");
    endtask

    task automatic test_prog_priority();
        logic [15:0] rb;
        mem_delay = 1;
        ba1_addr  = 22'h000010;
        expect_prog(1'b1, 2'd2, 22'h10, 16'hA55A, 2'b10);
        expect_read(2'd1, ba1_addr);
        prog_we   = 1'b1;
        prog_ba   = 2'd2;
        prog_addr = 22'h10;
        prog_data = 16'hA55A;
        prog_mask = 2'b10;
        ba_rd     = 4'b0010;
        wait_idle(40, "prog_priority");
        rb = mem_word(24'h800010);
        expect_prog(1'b0, 2'd2, 22'h10, 16'h0, 2'b11);
        prog_rd = 1'b1;
        wait_idle(30, "prog_readback");
        checks++;
        if (data_read !== rb) begin
            failures++;
            $display("FAIL prog_readback_data: data_read=%h, wanted %h", data_read, rb);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        mem_delay = 6;
        ba3_addr  = 22'h002000;
        expect_read(2'd3, ba3_addr);
        ba_rd = 4'b1000;
        while (exp_cmd.size() == 2 && n < 20) begin
            tick();
            n++;
        end
        tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({ba_ack, ba_dst, ba_dok, ba_rdy} !== 16'h0 || prog_ack !== 1'b0 || prog_rdy !== 1'b0 ||
            mem_rd !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 24'h0 || data_read !== 16'h0) begin
            failures++;
            $display("FAIL reset_mid: ack=%b dok=%b rd=%b we=%b addr=%h data=%h, wanted all 0",
                     ba_ack, ba_dok, mem_rd, mem_we, mem_addr, data_read);
        end
        exp_ack.delete();
        exp_cmd.delete();
        exp_rsp.delete();
        rst_n = 1'b1;
        repeat (8) tick();
        checks++;
        if (data_read !== 16'h0) begin
            failures++;
            $display("FAIL late_mem_ok: data_read=%h, wanted 0000", data_read);
        end
        mem_delay = 1;
        ba0_addr  = 22'h000042;
        expect_read(2'd0, ba0_addr);
        ba_rd = 4'b0001;
        wait_idle(30, "after_reset");
    endtask

    initial begin
        rst_n     = 1'b0;
        ba0_addr  = '0;
        ba1_addr  = '0;
        ba2_addr  = '0;
        ba3_addr  = '0;
        ba_rd     = 4'b0000;
        prog_we   = 1'b0;
        prog_rd   = 1'b0;
        prog_addr = '0;
        prog_ba   = 2'd0;
        prog_data = 16'h0;
        prog_mask = 2'b11;
        mem_dout  = 16'h0;
        mem_ok    = 1'b0;

        test_reset();
        test_single();
        test_burst_wrap();
        test_round_robin();
        test_back_to_back();
        test_withdrawn();
        test_prog_priority();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jtexterm_ba_resp.md
JTEXTERM_BA_RESP -- requirements
Module: jtexterm_ba_resp

Interface
REQ-001 Parameter BURST32, default 4'b1000, per-bank burst select: bit i=1 means bank i returns 2 words (32-bit slot), bit i=0 means 1 word.
REQ-002 Parameter AW, default 22, meaning per-bank word address width.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 ba0_addr..ba3_addr  input  AW each  word address from bank i requester.
REQ-006 ba_rd  input  4  read request per bank, held high by requester until ba_ack.
REQ-007 ba_ack  output  4  one-cycle request acceptance per bank.
REQ-008 ba_dst  output  4  first data word valid on data_read.
REQ-009 ba_dok  output  4  any data word valid on data_read.
REQ-010 ba_rdy  output  4  last data word valid, transaction complete.
REQ-011 data_read  output  16  read data bus shared by all banks.
REQ-012 prog_we / prog_rd  input  1 each  download write / read-back request, held until prog_ack.
REQ-013 prog_addr  input  AW, prog_ba  input  2, prog_data  input  16, prog_mask  input  2 (active low byte enables).
REQ-014 prog_ack  output  1  one-cycle acceptance; prog_rdy  output  1  one-cycle completion.
REQ-015 mem_addr  output  AW+2  {bank, word address}; mem_rd, mem_we  output  1 each; mem_din  output  16; mem_mask  output  2; mem_dout  input  16; mem_ok  input  1 (one-cycle, read data valid or write done).

Function
REQ-016 FSM states: IDLE, ACK, ISSUE, WAIT; all outputs registered.
REQ-017 IDLE: prog_we|prog_rd has absolute priority over ba_rd; else grant one bank by round-robin, search starting at (last granted bank + 1) mod 4.
REQ-018 IDLE -> ACK on any request; latch granted bank, address, burst length, prog data/mask, direction.
REQ-019 ACK: assert ba_ack[g] (or prog_ack) for exactly one cycle; -> ISSUE.
REQ-020 ISSUE: one-cycle pulse of mem_rd (or mem_we for prog_we) with mem_addr = {bank, addr + word}; word index 0 or 1; -> WAIT.
REQ-021 WAIT: hold until mem_ok; mem_rd/mem_we low; no timeout.
REQ-022 On mem_ok for a bank read: next cycle data_read = mem_dout and ba_dok[g]=1; ba_dst[g]=1 on word 0 only; ba_rdy[g]=1 on last word only.
REQ-023 Two-word burst: word 0 -> ISSUE with word=1; word 1 -> IDLE. Single-word: ba_dst, ba_dok, ba_rdy all high same cycle, -> IDLE.
REQ-024 Address add for word 1 wraps modulo 2^AW, bank field unchanged.
REQ-025 prog transactions are always single-word; prog_rdy pulses the cycle after mem_ok; prog read-back data on data_read; no ba_* strobes.
REQ-026 data_read holds last value between transactions; dst/dok/rdy/ack are single-cycle pulses, at most one bank bit set.
REQ-027 Requests deasserted before grant are ignored; ba_rd changes during a transaction never affect it.
REQ-028 Return to IDLE and re-arbitration take one cycle; min transaction (mem_ok immediate) = ACK+ISSUE+WAIT+1 = 4 cycles single-word.

Reset
REQ-029 rst_n=0 sampled on a clock edge: state IDLE, all strobes and mem_rd/mem_we 0, data_read 0, mem_addr 0, last-granted pointer 3 (bank 0 first), word index 0.
REQ-030 Reset mid-transaction aborts immediately; pending mem_ok after reset is ignored.

Verification
REQ-031 ba_rd=4'b0001, ba0_addr=22'h1234, mem_ok 2 cycles after mem_rd, mem_dout=16'hBEEF -> ba_ack[0] pulse, mem_addr=24'h001234, then ba_dst[0]=ba_dok[0]=ba_rdy[0]=1 with data_read=16'hBEEF in same cycle.
REQ-032 ba_rd=4'b1000, ba3_addr=22'h3FFFFF, words 16'h1111/16'h2222 -> mem_addr 24'hFFFFFF then 24'hC00000; dst+dok on 16'h1111; dok+rdy on 16'h2222.
REQ-033 ba_rd=4'b1111 held, each released after its ack -> grant order 0,1,2,3; then ba_rd=4'b0101 -> order continues 0,2.
REQ-034 prog_we=1 with ba_rd=4'b0010 same cycle, prog_ba=2, prog_addr=22'h10, prog_data=16'hA55A, mask=2'b10 -> prog_ack first, mem_we with mem_addr=24'h800010, mem_din=16'hA55A, mem_mask=2'b10, prog_rdy, then bank 1 served.
REQ-035 rst_n=0 asserted during WAIT of a bank 3 burst -> next edge all outputs 0, state IDLE; late mem_ok produces no ba_dok; new ba_rd=4'b0001 served normally.
